// File: rtl/mask_row_serializer.sv
// Mask-row serializer: accepts IMG_W-bit exposure-mask rows and shifts them into the sensor mask chain
// LANE_W bits at a time. Optional frame checksum outputs are compiled in with `define MASK_CHECKSUM_EN.
module mask_row_serializer #(
  parameter int IMG_W  = 300,
  parameter int IMG_H  = 300,
  parameter int LANE_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       frame_start,
  input  logic [IMG_W-1:0]           row_in,
  input  logic                       row_valid,
  output logic                       row_ready,
  output logic [LANE_W-1:0]          sensor_data,
  output logic                       sensor_shift,
  output logic                       sensor_row_load,
  output logic                       sensor_frame_done,
  output logic [$clog2(IMG_H+1)-1:0] row_count,
  output logic                       busy,
  output logic                       start_err
`ifdef MASK_CHECKSUM_EN
  ,
  output logic [IMG_W-1:0]           frame_checksum,
  output logic                       checksum_valid
`endif
);

  localparam int NCHUNK  = (IMG_W + LANE_W - 1) / LANE_W;
  localparam int SH_W    = NCHUNK * LANE_W;
  localparam int CNT_W   = $clog2(IMG_H + 1);
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK     = CHUNK_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0]   ROWS_PER_FRAME = CNT_W'(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROW,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     shreg_q, shreg_d;
  logic [LANE_W-1:0]   data_q, data_d;
  logic [CHUNK_W-1:0]  chunk_cnt_q, chunk_cnt_d;
  logic [CNT_W-1:0]    row_count_q, row_count_d;
  logic                shift_q, shift_d;
  logic                row_load_q, row_load_d;
  logic                frame_done_q, frame_done_d;
  logic                start_err_q, start_err_d;
  logic [SH_W-1:0]     row_pad;
`ifdef MASK_CHECKSUM_EN
  logic [IMG_W-1:0]    acc_q, acc_d;
  logic [IMG_W-1:0]    cksum_q, cksum_d;
  logic                cksum_vld_q, cksum_vld_d;
`endif

  // Zero-extend to a whole number of chunks so the last chunk's unused bits shift out as 0.
  assign row_pad = SH_W'(row_in);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    chunk_cnt_d  = chunk_cnt_q;
    row_count_d  = row_count_q;
    shift_d      = 1'b0;
    row_load_d   = 1'b0;
    frame_done_d = 1'b0;
    start_err_d  = frame_start && (state_q != S_IDLE);
`ifdef MASK_CHECKSUM_EN
    acc_d        = acc_q;
    cksum_d      = cksum_q;
    cksum_vld_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d     = S_WAIT_ROW;
          row_count_d = '0;
`ifdef MASK_CHECKSUM_EN
          acc_d       = '0;
`endif
        end
      end
      S_WAIT_ROW: begin
        // Chunk 0 is presented straight from the capture so it appears the cycle after the handshake.
        if (row_valid) begin
          state_d     = S_SHIFT;
          data_d      = row_pad[LANE_W-1:0];
          shreg_d     = row_pad >> LANE_W;
          chunk_cnt_d = '0;
          shift_d     = 1'b1;
`ifdef MASK_CHECKSUM_EN
          acc_d       = acc_q ^ row_in;
`endif
        end
      end
      S_SHIFT: begin
        if (chunk_cnt_q == LAST_CHUNK) begin
          state_d     = S_LOAD;
          row_load_d  = 1'b1;
          row_count_d = row_count_q + CNT_W'(1);
        end else begin
          data_d      = shreg_q[LANE_W-1:0];
          shreg_d     = shreg_q >> LANE_W;
          chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
          shift_d     = 1'b1;
        end
      end
      S_LOAD: begin
        if (row_count_q == ROWS_PER_FRAME) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
`ifdef MASK_CHECKSUM_EN
          cksum_d      = acc_q;
          cksum_vld_d  = 1'b1;
`endif
        end else begin
          state_d = S_WAIT_ROW;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      data_q       <= '0;
      chunk_cnt_q  <= '0;
      row_count_q  <= '0;
      shift_q      <= 1'b0;
      row_load_q   <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
`ifdef MASK_CHECKSUM_EN
      acc_q        <= '0;
      cksum_q      <= '0;
      cksum_vld_q  <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      chunk_cnt_q  <= chunk_cnt_d;
      row_count_q  <= row_count_d;
      shift_q      <= shift_d;
      row_load_q   <= row_load_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
`ifdef MASK_CHECKSUM_EN
      acc_q        <= acc_d;
      cksum_q      <= cksum_d;
      cksum_vld_q  <= cksum_vld_d;
`endif
    end
  end

  // Strobes are masked while frozen so a stalled cycle never repeats a shift or load.
  assign row_ready         = (state_q == S_WAIT_ROW);
  assign busy              = (state_q != S_IDLE);
  assign sensor_data       = data_q;
  assign sensor_shift      = shift_q & clk_en;
  assign sensor_row_load   = row_load_q & clk_en;
  assign sensor_frame_done = frame_done_q & clk_en;
  assign start_err         = start_err_q & clk_en;
  assign row_count         = row_count_q;
`ifdef MASK_CHECKSUM_EN
  assign frame_checksum    = cksum_q;
  assign checksum_valid    = cksum_vld_q & clk_en;
`endif

endmodule

// File: tb/tb_mask_row_serializer.sv
// Directed self-checking bench for mask_row_serializer (IMG_W=300, IMG_H=4, LANE_W=32);
// the checksum scenario is exercised when MASK_CHECKSUM_EN is defined.
module tb_mask_row_serializer;

  localparam int W  = 300;
  localparam int H  = 4;
  localparam int LW = 32;
  typedef logic [W-1:0] row_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_en;
  logic             frame_start;
  row_t             row_in;
  logic             row_valid;
  logic             row_ready;
  logic [LW-1:0]    sensor_data;
  logic             sensor_shift;
  logic             sensor_row_load;
  logic             sensor_frame_done;
  logic [2:0]       row_count;
  logic             busy;
  logic             start_err;
`ifdef MASK_CHECKSUM_EN
  row_t             frame_checksum;
  logic             checksum_valid;
`endif

  mask_row_serializer #(.IMG_W(W), .IMG_H(H), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .frame_start(frame_start),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .sensor_data(sensor_data), .sensor_shift(sensor_shift),
    .sensor_row_load(sensor_row_load), .sensor_frame_done(sensor_frame_done),
    .row_count(row_count), .busy(busy), .start_err(start_err)
`ifdef MASK_CHECKSUM_EN
    , .frame_checksum(frame_checksum), .checksum_valid(checksum_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_q[$], fs_q[$], load_q[$], done_q[$], chunk_cyc_q[$];
  logic [LW-1:0] chunk_q[$];
  int err_n, gate_viol, rdy_low;
  row_t cs_q[$];
  int cs_with_done;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observation happens on the falling edge, away from DUT updates and bench drives.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clk_en && row_valid && row_ready) hs_q.push_back(cyc);
      if (clk_en && frame_start && !busy) fs_q.push_back(cyc);
      if (sensor_shift) begin
        chunk_q.push_back(sensor_data);
        chunk_cyc_q.push_back(cyc);
      end
      if (sensor_row_load) load_q.push_back(cyc);
      if (sensor_frame_done) done_q.push_back(cyc);
      if (start_err) err_n++;
      if (!clk_en && (sensor_shift || sensor_row_load || sensor_frame_done || start_err)) gate_viol++;
      if (busy && !row_ready) rdy_low++;
`ifdef MASK_CHECKSUM_EN
      if (checksum_valid) begin
        cs_q.push_back(frame_checksum);
        if (sensor_frame_done) cs_with_done++;
      end
`endif
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; clk_en = 1'b1; frame_start = 1'b0; row_valid = 1'b0; row_in = '0;
    repeat (2) @(posedge clk);
    hs_q.delete(); fs_q.delete(); load_q.delete(); done_q.delete();
    chunk_q.delete(); chunk_cyc_q.delete(); cs_q.delete();
    err_n = 0; gate_viol = 0; rdy_low = 0; cs_with_done = 0;
    #2 rst_n = 1'b1;
  endtask

  task automatic start_frame();
    @(posedge clk); #2 frame_start = 1'b1;
    @(posedge clk); #2 frame_start = 1'b0;
  endtask

  task automatic send_row(input row_t r, input string tag);
    bit got = 0;
    @(posedge clk); #2 row_in = r; row_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (row_ready) begin got = 1; break; end
    end
    if (!got) check({tag, "_ready_timeout"}, 0, 1);
    @(posedge clk); #2 row_valid = 1'b0;
  endtask

  function automatic logic [40:0] all_outs();
    return {row_ready, busy, sensor_shift, sensor_row_load, sensor_frame_done,
            start_err, row_count, sensor_data};
  endfunction

  row_t          r_alt, r_cnt, ra, rb, rc;
  logic [LW-1:0] exp_c[10];

  initial begin
    // Reset state and idle without frame_start
    rst_n = 1'b0; clk_en = 1'b1; frame_start = 1'b0; row_valid = 1'b0; row_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 320'(all_outs()), 0);
    do_reset();
    repeat (4) @(negedge clk);
    check("idle_busy", 320'(busy), 0);
    check("idle_ready", 320'(row_ready), 0);

    // One row of alternating pixels
    r_alt = {150{2'b01}};
    start_frame();
    send_row(r_alt, "t1");
    repeat (14) @(negedge clk);
    check("t1_nchunks", 320'(chunk_q.size()), 10);
    for (int k = 0; k < 10; k++)
      check($sformatf("t1_chunk%0d", k), 320'(chunk_q[k]), (k < 9) ? 320'h5555_5555 : 320'h0000_0555);
    check("t1_first_chunk_lat", 320'(chunk_cyc_q[0] - hs_q[0]), 1);
    check("t1_nloads", 320'(load_q.size()), 1);
    check("t1_load_lat", 320'(load_q[0] - hs_q[0]), 11);
    check("t1_row_count", 320'(row_count), 1);
    check("t1_ready_low", 320'(rdy_low), 11);
    check("t1_back_waiting", 320'(row_ready), 1);

    // Full 4-row frame with row_valid held; frame_start and row_valid arrive together
    do_reset();
    @(posedge clk); #2 frame_start = 1'b1; row_valid = 1'b1; row_in = r_alt;
    @(posedge clk); #2 frame_start = 1'b0;
    for (int i = 0; i < 100 && done_q.size() == 0; i++) @(negedge clk);
    check("t2_ndone", 320'(done_q.size()), 1);
    @(posedge clk); #2 row_valid = 1'b0;
    check("t2_first_hs", 320'(hs_q[0] - fs_q[0]), 1);
    check("t2_nhs", 320'(hs_q.size()), 4);
    check("t2_nloads", 320'(load_q.size()), 4);
    if (load_q.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("t2_load_gap%0d", i), 320'(load_q[i+1] - load_q[i]), 12);
      check("t2_done_lat", 320'(done_q[0] - load_q[3]), 1);
    end
    check("t2_nchunks", 320'(chunk_q.size()), 40);
    repeat (3) @(negedge clk);
    check("t2_row_count", 320'(row_count), 4);
    check("t2_idle_busy", 320'(busy), 0);
    check("t2_idle_ready", 320'(row_ready), 0);

    // Distinct chunks; clock enable toggled through SHIFT
    for (int k = 0; k < 9; k++) begin
      r_cnt[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
      exp_c[k] = 32'hC0DE_0000 + 32'(k);
    end
    r_cnt[288 +: 12] = 12'hABC;
    exp_c[9] = 32'h0000_0ABC;
    do_reset();
    start_frame();
    send_row(r_cnt, "t3");
    for (int i = 0; i < 24; i++) begin
      clk_en = ~clk_en;
      @(posedge clk); #2;
    end
    clk_en = 1'b1;
    repeat (12) @(negedge clk);
    check("t3_nchunks", 320'(chunk_q.size()), 10);
    for (int k = 0; k < 10; k++)
      check($sformatf("t3_chunk%0d", k), 320'(chunk_q[k]), 320'(exp_c[k]));
    check("t3_nloads", 320'(load_q.size()), 1);
    check("t3_gated_strobes", 320'(gate_viol), 0);
    check("t3_row_count", 320'(row_count), 1);

    // frame_start while shifting, then reset in the middle of the row
    do_reset();
    start_frame();
    send_row(r_cnt, "t4");
    @(posedge clk); #2 frame_start = 1'b1;
    @(posedge clk); #2 frame_start = 1'b0;
    begin
      bit got = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (chunk_q.size() == 5) begin got = 1; break; end
      end
      if (!got) check("t4_chunk5_timeout", 0, 1);
    end
    #1 rst_n = 1'b0;
    #1 check("t4_reset_outputs", 320'(all_outs()), 0);
    check("t4_start_err", 320'(err_n), 1);
    for (int k = 0; k < 5; k++)
      check($sformatf("t4_chunk%0d", k), 320'(chunk_q[k]), 320'(exp_c[k]));
    repeat (3) @(posedge clk);
    check("t4_no_load", 320'(load_q.size()), 0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_idle_busy", 320'(busy), 0);
    check("t4_no_load_after", 320'(load_q.size()), 0);

`ifdef MASK_CHECKSUM_EN
    // Checksum over rows A,B,C,A leaves B^C
    ra = {10{30'h2AAA_AAAA}};
    rb = {75{4'h3}};
    rc = {60{5'h11}};
    do_reset();
    start_frame();
    send_row(ra, "t5a");
    send_row(rb, "t5b");
    send_row(rc, "t5c");
    send_row(ra, "t5d");
    for (int i = 0; i < 40 && done_q.size() == 0; i++) @(negedge clk);
    @(negedge clk);
    check("t5_ncs", 320'(cs_q.size()), 1);
    check("t5_cs_with_done", 320'(cs_with_done), 1);
    check("t5_checksum", 320'(cs_q[0]), 320'(rb ^ rc));
    repeat (3) @(negedge clk);
    check("t5_checksum_hold", 320'(frame_checksum), 320'(rb ^ rc));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
